// File: rtl/airi5c_hasti_bram_bridge.sv
// HASTI (AHB-Lite) slave in front of a RAMB36: writes on port A, reads on port B,
// zero wait states, read-after-write forwarding and the two-cycle ERROR response.
module airi5c_hasti_bram_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hready_in,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] bram_addra,
  output logic        bram_ena,
  output logic [3:0]  bram_wea,
  output logic [31:0] bram_dia,
  output logic [31:0] bram_addrb,
  output logic        bram_enb,
  input  logic [31:0] bram_dob
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   off;
  logic [AW-1:0] word_idx;
  logic [3:0]    strb;
  logic          in_range, misalign, err, accept, xfer_ok, rd_ok, wr_ok;
  logic          wr_v, rd_v;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_strb, fwd_strb;
  logic [31:0]   fwd_data, merged;

  // Handshake: a transfer is taken when hsel & htrans[1] & hready_in are high at a
  // clock edge; this slave drops hready only in ERR1, which holds the next address phase.
  always_comb begin
    off      = haddr - BASE_ADDR;
    word_idx = AW'(off >> 2);
    in_range = ({1'b0, haddr} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr} < LIMIT);
    misalign = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    err      = (hsize > 3'd2) || misalign || !in_range;
    accept   = hsel && htrans[1] && hready_in;
    xfer_ok  = accept && !err && !reset;
    rd_ok    = xfer_ok && !hwrite;
    wr_ok    = xfer_ok && hwrite;
    case (hsize)
      3'd0:    strb = 4'b0001 << haddr[1:0];
      3'd1:    strb = 4'b0011 << {haddr[1], 1'b0};
      default: strb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_v     <= 1'b0;
      wr_idx   <= '0;
      wr_strb  <= 4'b0;
      rd_v     <= 1'b0;
      fwd_strb <= 4'b0;
      fwd_data <= 32'b0;
    end else begin
      state_q <= state_d;
      wr_v    <= wr_ok;
      rd_v    <= rd_ok;
      if (wr_ok) begin
        wr_idx  <= word_idx;
        wr_strb <= strb;
      end
      // Port B reads the old word while port A writes it; remember the written lanes.
      if (rd_ok) begin
        fwd_strb <= (wr_v && (wr_idx == word_idx)) ? wr_strb : 4'b0;
        fwd_data <= hwdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: state_d = (accept && err) ? S_ERR1 : S_IDLE;
      S_ERR1:         state_d = S_ERR2;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hready     = (state_q != S_ERR1);
    hresp      = (state_q != S_IDLE);
    bram_ena   = wr_v && !reset;
    bram_wea   = bram_ena ? wr_strb : 4'b0;
    bram_dia   = bram_ena ? hwdata : 32'b0;
    bram_addra = 32'({wr_idx, 5'b0});
    bram_enb   = rd_ok;
    bram_addrb = rd_ok ? 32'({word_idx, 5'b0}) : 32'b0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = fwd_strb[i] ? fwd_data[8*i +: 8] : bram_dob[8*i +: 8];
    hrdata = rd_v ? merged : 32'b0;
  end

endmodule

// File: tb/tb_airi5c_hasti_bram_bridge.sv
// Directed bench for the HASTI-to-BRAM bridge with a read-first dual-port RAM model.
module tb_airi5c_hasti_bram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hrdata;
  logic        hready, hresp;
  logic [31:0] bram_addra, bram_dia, bram_addrb;
  logic        bram_ena, bram_enb;
  logic [3:0]  bram_wea;
  logic [31:0] bram_dob;

  logic [31:0] mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_idx;
  logic [31:0] poke_data;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] BASE = 32'h8000_0000;

  always #5 clk = ~clk;

  airi5c_hasti_bram_bridge dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hready_in(hready), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .bram_addra(bram_addra), .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_dia(bram_dia),
    .bram_addrb(bram_addrb), .bram_enb(bram_enb), .bram_dob(bram_dob)
  );

  // RAMB36 model: read-first port B, byte-enabled port A, backdoor poke for preloading.
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    if (bram_ena)
      for (int i = 0; i < 4; i++)
        if (bram_wea[i]) mem[bram_addra[20:5]][8*i +: 8] <= bram_dia[8*i +: 8];
    if (bram_enb) bram_dob <= mem[bram_addrb[20:5]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [2:0] sz);
    hsel = 1'b1; htrans = 2'b10; hwrite = w; haddr = a; hsize = sz;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
  endtask

  task automatic poke(input logic [15:0] idx, input logic [31:0] d);
    poke_en = 1'b1; poke_idx = idx; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_hready"}, 32'(hready), 32'd1);
    chk({tag, "_hresp"}, 32'(hresp), 32'd0);
    chk({tag, "_hrdata"}, hrdata, 32'd0);
    chk({tag, "_ena"}, 32'(bram_ena), 32'd0);
    chk({tag, "_wea"}, 32'(bram_wea), 32'd0);
    chk({tag, "_enb"}, 32'(bram_enb), 32'd0);
    chk({tag, "_addra"}, bram_addra, 32'd0);
    chk({tag, "_addrb"}, bram_addrb, 32'd0);
    chk({tag, "_dia"}, bram_dia, 32'd0);
  endtask

  // Single errored transfer from IDLE, bus idle afterwards.
  task automatic err_seq(input string tag, input logic w, input logic [31:0] a, input logic [2:0] sz);
    bus(w, a, sz);
    @(negedge clk);
    chk({tag, "_addr_enb"}, 32'(bram_enb), 32'd0);
    step();
    idle();
    @(negedge clk);
    chk({tag, "_e1_hready"}, 32'(hready), 32'd0);
    chk({tag, "_e1_hresp"}, 32'(hresp), 32'd1);
    chk({tag, "_e1_ena"}, 32'(bram_ena), 32'd0);
    step();
    @(negedge clk);
    chk({tag, "_e2_hready"}, 32'(hready), 32'd1);
    chk({tag, "_e2_hresp"}, 32'(hresp), 32'd1);
    step();
    @(negedge clk);
    chk({tag, "_post_hresp"}, 32'(hresp), 32'd0);
    step();
  endtask

  task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus(1'b0, a, 3'd2);
    @(negedge clk);
    chk({tag, "_enb"}, 32'(bram_enb), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk({tag, "_hrdata"}, hrdata, exp);
    chk({tag, "_hready"}, 32'(hready), 32'd1);
    step();
  endtask

  initial begin
    reset = 1'b1;
    hwdata = 32'h0;
    idle();
    repeat (3) step();
    chk_reset_vals("rst_held");
    reset = 1'b0;
    chk_reset_vals("rst_rel");
    step();

    // Word write 0xDEADBEEF to BASE+0x10, then read it back after an idle cycle.
    bus(1'b1, BASE + 32'h10, 3'd2);
    @(negedge clk);
    chk("w1_addr_ena", 32'(bram_ena), 32'd0);
    step();
    idle();
    hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("w1_ena", 32'(bram_ena), 32'd1);
    chk("w1_wea", 32'(bram_wea), 32'hF);
    chk("w1_addra", bram_addra, 32'h80);
    chk("w1_dia", bram_dia, 32'hDEAD_BEEF);
    chk("w1_hready", 32'(hready), 32'd1);
    step();
    bus(1'b0, BASE + 32'h10, 3'd2);
    @(negedge clk);
    chk("r1_addrb", bram_addrb, 32'h80);
    chk("r1_enb", 32'(bram_enb), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("r1_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("r1_mem", mem[4], 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("r1_idle_hrdata", hrdata, 32'd0);
    step();

    // Byte write 0xAA into lane 3 of a word holding 0x11223344.
    poke(16'd4, 32'h1122_3344);
    bus(1'b1, BASE + 32'h13, 3'd0);
    step();
    idle();
    hwdata = 32'hAA00_0000;
    @(negedge clk);
    chk("wb_wea", 32'(bram_wea), 32'b1000);
    step();
    read_word("rb", BASE + 32'h10, 32'hAA22_3344);

    // Half write 0xBEEF to BASE+0x20 followed immediately by a read of that word.
    poke(16'd8, 32'h1234_5678);
    bus(1'b1, BASE + 32'h20, 3'd1);
    step();
    bus(1'b0, BASE + 32'h20, 3'd2);
    hwdata = 32'h0000_BEEF;
    @(negedge clk);
    chk("fw_wea", 32'(bram_wea), 32'b0011);
    chk("fw_enb", 32'(bram_enb), 32'd1);
    chk("fw_hready", 32'(hready), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("fw_hrdata", hrdata, 32'h1234_BEEF);
    step();
    chk("fw_mem", mem[8], 32'h1234_BEEF);

    // Misaligned word write; the read held behind it is taken in ERR2.
    bus(1'b1, BASE + 32'h2, 3'd2);
    hwdata = 32'hFFFF_FFFF;
    step();
    bus(1'b0, BASE + 32'h10, 3'd2);
    @(negedge clk);
    chk("mis_e1_hready", 32'(hready), 32'd0);
    chk("mis_e1_hresp", 32'(hresp), 32'd1);
    chk("mis_e1_ena", 32'(bram_ena), 32'd0);
    chk("mis_e1_enb", 32'(bram_enb), 32'd0);
    step();
    @(negedge clk);
    chk("mis_e2_hready", 32'(hready), 32'd1);
    chk("mis_e2_hresp", 32'(hresp), 32'd1);
    chk("mis_e2_enb", 32'(bram_enb), 32'd1);
    step();
    idle();
    @(negedge clk);
    chk("mis_next_hresp", 32'(hresp), 32'd0);
    chk("mis_next_hrdata", hrdata, 32'hAA22_3344);
    step();

    // Out-of-range, below-base and illegal-size transfers.
    err_seq("oor", 1'b0, BASE + 32'h0004_0000, 3'd2);
    err_seq("below", 1'b0, BASE - 32'h4, 3'd2);
    hwdata = 32'h0BAD_0BAD;
    err_seq("sz3", 1'b1, BASE + 32'h10, 3'd3);
    read_word("sz3_rd", BASE + 32'h10, 32'hAA22_3344);
    chk("sz3_mem", mem[4], 32'hAA22_3344);

    // Reset during a write data phase drops the write.
    poke(16'd12, 32'hCAFE_F00D);
    bus(1'b1, BASE + 32'h30, 3'd2);
    step();
    idle();
    reset = 1'b1;
    hwdata = 32'h5555_5555;
    @(negedge clk);
    chk("rw_ena", 32'(bram_ena), 32'd0);
    chk("rw_wea", 32'(bram_wea), 32'd0);
    step();
    reset = 1'b0;
    chk_reset_vals("rw_after");
    step();
    read_word("rw_rd", BASE + 32'h30, 32'hCAFE_F00D);

    // Reset during ERR1 returns to IDLE with OKAY.
    bus(1'b0, BASE + 32'h1, 3'd1);
    step();
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk("re_e1_hresp", 32'(hresp), 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("re_hresp", 32'(hresp), 32'd0);
    chk("re_hready", 32'(hready), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
